fixed_point_engine: RTL and testbench
=====================================

FIXED_POINT_ENGINE -- requirements
Module: fixed_point_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width in bits; it must be a multiple of SLICE.
REQ-002 The block SHALL have parameter FBITS, default 10, number of fraction bits; WIDTH+FBITS must be even.
REQ-003 The block SHALL have parameter SLICE, default 16, width of the internal SLICE x SLICE unsigned multiplier.
REQ-004 The block SHALL have port clk, input, 1 bit, clock; all state changes on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, request to begin an operation.
REQ-007 The block SHALL have port operation, input, 2 bits, operation code: 0 ADD, 1 SUB, 2 MUL, 3 SQRT.
REQ-008 The block SHALL have ports operand_1 and operand_2, inputs, WIDTH bits each, signed two's-complement Q(WIDTH-FBITS).FBITS values.
REQ-009 The block SHALL have port result, output, WIDTH bits, result of the last completed operation.
REQ-010 The block SHALL have port ready, output, 1 bit, one-cycle pulse marking result valid.
REQ-011 The block SHALL have port busy, output, 1 bit, high while a multi-cycle operation is in progress.
REQ-012 The block SHALL have port overflow, output, 1 bit, saturation or invalid-operand flag; it is valid with ready.

Function
REQ-013 The FSM SHALL use states IDLE, MUL, SQRT and DONE.
REQ-014 In IDLE or DONE, start=1 SHALL latch operation, operand_1 and operand_2. ADD/SUB go to DONE, MUL goes to MUL, SQRT goes to SQRT.
REQ-015 start SHALL be ignored in MUL and SQRT; later changes to the operand and operation inputs SHALL NOT affect an accepted operation.
REQ-016 busy SHALL be 1 exactly in MUL and SQRT; ready SHALL be 1 exactly in DONE; DONE SHALL go to IDLE unless start=1, which allows back-to-back issue.
REQ-017 result and overflow SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-018 ADD/SUB SHALL compute a WIDTH+1-bit signed sum or difference and saturate to 0x7FF..F or 0x800..0 on overflow, with overflow=1; latency is 1 cycle (ready is high in the cycle after the start edge).
REQ-019 MUL SHALL multiply operand magnitudes using one SLICE x SLICE product per cycle, N*N cycles with N=WIDTH/SLICE, accumulating shifted partial products into a 2*WIDTH-bit register.
REQ-020 The MUL result SHALL be the magnitude shifted right by FBITS, truncated toward zero, then negated if the operand signs differ.
REQ-021 If the MUL value is outside the signed WIDTH range, the result SHALL saturate with overflow=1.
REQ-022 MUL latency SHALL be N*N+1 cycles; 5 cycles at the default parameters.
REQ-023 The magnitude of 0x800..0 SHALL be handled as 2^(WIDTH-1) without loss.
REQ-024 SQRT SHALL compute floor(sqrt(operand_1 << FBITS)) using the restoring digit-by-digit algorithm, one result bit per cycle, K=(WIDTH+FBITS)/2 cycles.
REQ-025 SQRT latency SHALL be K+1 cycles; 22 cycles at the default parameters.
REQ-026 SQRT of a negative operand_1 SHALL give result 0 and overflow=1 with the same latency.
REQ-027 SQRT of 0 SHALL give 0 with overflow=0.
REQ-028 Unused operation encodings SHALL NOT exist; all four codes are defined.

Reset
REQ-029 On reset=1, at any time including mid-operation, the block SHALL asynchronously force state=IDLE, result=0, ready=0, busy=0 and overflow=0, and clear all iteration counters and accumulators.
REQ-030 An operation interrupted by reset SHALL be discarded and SHALL produce no ready pulse.
REQ-031 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-032 The bench SHALL cover ADD of 0x00000C00 (3.0) and 0x00000800 (2.0) -> result 0x00001400, overflow 0, ready one cycle after start, busy never high.
REQ-033 The bench SHALL cover ADD of 0x7FFFFFFF and 0x00000400 -> result 0x7FFFFFFF, overflow 1; also SUB of 0x80000000 and 0x00000001 -> result 0x80000000, overflow 1.
REQ-034 The bench SHALL cover MUL of 0x00000C00 (3.0) and 0xFFFFF600 (-2.5) -> result 0xFFFFE200 (-7.5), overflow 0, ready exactly 5 cycles after start, busy high for 4 cycles.
REQ-035 The bench SHALL cover SQRT of 0x00004000 (16.0) -> result 0x00001000 at 22 cycles, and SQRT of 0x00000800 (2.0) -> result 0x000005A8.
REQ-036 The bench SHALL cover SQRT of 0xFFFFFC00 (-1.0) -> result 0, overflow 1 at 22 cycles; also start pulsed during busy -> ignored, with the original result delivered unchanged.
REQ-037 The bench SHALL cover reset asserted in the 3rd MUL cycle -> busy, ready and result read 0 immediately with no later ready pulse; then ADD of 1.0 and 1.0 after reset -> result 0x00000800.

Source files
------------

// File: rtl/fixed_point_engine.sv
// Fixed-point arithmetic engine for signed Q(WIDTH-FBITS).FBITS values.
// ADD/SUB complete in one cycle. MUL uses one SLICE x SLICE partial product
// per cycle. SQRT uses a restoring digit-by-digit root, one bit per cycle.
//
// Handshake: start is sampled only in IDLE or DONE, and the operation and
// operands are captured on that edge. ready is high for exactly one cycle,
// in DONE. result and overflow are valid with ready and hold until the next
// DONE. busy is high while MUL or SQRT iterates, and start is ignored then.
module fixed_point_engine #(
    parameter int WIDTH = 32,
    parameter int FBITS = 10,
    parameter int SLICE = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       operation,
    input  logic [WIDTH-1:0] operand_1,
    input  logic [WIDTH-1:0] operand_2,
    output logic [WIDTH-1:0] result,
    output logic             ready,
    output logic             busy,
    output logic             overflow,
    output logic [1:0]       o_dbg_state
);
    localparam int N  = WIDTH / SLICE;
    localparam int NN = N * N;
    localparam int K  = (WIDTH + FBITS) / 2;
    localparam int CW = $clog2(((NN > K) ? NN : K) + 1);

    localparam logic [1:0] OP_ADD  = 2'd0;
    localparam logic [1:0] OP_SUB  = 2'd1;
    localparam logic [1:0] OP_MUL  = 2'd2;
    localparam logic [1:0] OP_SQRT = 2'd3;

    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, SQRT, DONE} state_t;

    state_t r_state, w_next;

    logic [WIDTH-1:0]   r_result;
    logic               r_overflow;
    logic [CW-1:0]      r_cnt;
    logic               r_neg;       // MUL: signs differ; SQRT: negative operand
    logic [WIDTH-1:0]   r_mag_a;
    logic [WIDTH-1:0]   r_mag_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*K-1:0]     r_rad;
    logic [K:0]         r_rem;
    logic [K-1:0]       r_root;

    logic w_accept;
    assign w_accept = start && (r_state == IDLE || r_state == DONE);

    // ADD/SUB: one extra bit catches overflow; saturate toward the true sign.
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_addsub_res;
    logic               w_addsub_ovf;
    assign w_sum = (operation == OP_SUB)
                 ? {operand_1[WIDTH-1], operand_1} - {operand_2[WIDTH-1], operand_2}
                 : {operand_1[WIDTH-1], operand_1} + {operand_2[WIDTH-1], operand_2};
    assign w_addsub_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    assign w_addsub_res = w_addsub_ovf ? (w_sum[WIDTH] ? MINV : MAXV) : w_sum[WIDTH-1:0];

    // Magnitudes fit in WIDTH unsigned bits, including 2^(WIDTH-1).
    logic [WIDTH-1:0] w_mag_1, w_mag_2;
    assign w_mag_1 = operand_1[WIDTH-1] ? (~operand_1 + 1'b1) : operand_1;
    assign w_mag_2 = operand_2[WIDTH-1] ? (~operand_2 + 1'b1) : operand_2;

    // MUL: r_cnt walks the slice pairs, slice index a = cnt / N, b = cnt % N.
    int                 w_ia, w_ib, w_shift;
    logic [SLICE-1:0]   w_sa, w_sb;
    logic [2*SLICE-1:0] w_prod;
    logic [2*WIDTH-1:0] w_pp, w_acc_next, w_mq;
    logic [WIDTH-1:0]   w_mq_lo, w_mul_res;
    logic               w_mq_hi_zero, w_pos_ovf, w_neg_ovf, w_mul_ovf, w_mul_last;

    assign w_ia       = int'(r_cnt) / N;
    assign w_ib       = int'(r_cnt) % N;
    assign w_shift    = (w_ia + w_ib) * SLICE;
    assign w_sa       = r_mag_a[w_ia*SLICE +: SLICE];
    assign w_sb       = r_mag_b[w_ib*SLICE +: SLICE];
    assign w_prod     = {{SLICE{1'b0}}, w_sa} * {{SLICE{1'b0}}, w_sb};
    assign w_pp       = {{(2*WIDTH-2*SLICE){1'b0}}, w_prod} << w_shift;
    assign w_acc_next = r_acc + w_pp;
    assign w_mul_last = (r_cnt == CW'(NN - 1));

    // Truncate toward zero on the magnitude, then range-check per sign.
    assign w_mq         = w_acc_next >> FBITS;
    assign w_mq_lo      = w_mq[WIDTH-1:0];
    assign w_mq_hi_zero = (w_mq[2*WIDTH-1:WIDTH] == '0);
    assign w_pos_ovf    = !w_mq_hi_zero || w_mq[WIDTH-1];
    assign w_neg_ovf    = !w_mq_hi_zero || (w_mq[WIDTH-1] && (|w_mq[WIDTH-2:0]));
    assign w_mul_ovf    = r_neg ? w_neg_ovf : w_pos_ovf;
    assign w_mul_res    = r_neg ? (w_neg_ovf ? MINV : (~w_mq_lo + 1'b1))
                                : (w_pos_ovf ? MAXV : w_mq_lo);

    // SQRT: bring down two radicand bits, try subtracting (4*root + 1).
    logic [K+2:0] w_rem_sh, w_trial, w_diff, w_rem_full;
    logic [K-1:0] w_root_nx;
    logic         w_ge, w_sqrt_last, w_unused_bits;

    assign w_rem_sh    = {r_rem, r_rad[2*K-1 -: 2]};
    assign w_trial     = {1'b0, r_root, 2'b01};
    assign w_ge        = (w_rem_sh >= w_trial);
    assign w_diff      = w_rem_sh - w_trial;
    assign w_rem_full  = w_ge ? w_diff : w_rem_sh;
    assign w_root_nx   = {r_root[K-2:0], w_ge};
    assign w_sqrt_last = (r_cnt == CW'(K - 1));
    // The remainder never exceeds 2*root, so the top two bits are always zero.
    assign w_unused_bits = ^w_rem_full[K+2:K+1];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (r_state == DONE) w_next = IDLE;
                if (start) begin
                    case (operation)
                        OP_MUL:  w_next = MUL;
                        OP_SQRT: w_next = SQRT;
                        default: w_next = DONE;
                    endcase
                end
            end
            MUL:     if (w_mul_last)  w_next = DONE;
            SQRT:    if (w_sqrt_last) w_next = DONE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in MUL/SQRT, publish on entry to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result   <= '0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
            r_neg      <= 1'b0;
            r_mag_a    <= '0;
            r_mag_b    <= '0;
            r_acc      <= '0;
            r_rad      <= '0;
            r_rem      <= '0;
            r_root     <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_rem <= '0;
            r_root <= '0;
            case (operation)
                OP_ADD, OP_SUB: begin
                    r_result   <= w_addsub_res;
                    r_overflow <= w_addsub_ovf;
                end
                OP_MUL: begin
                    r_mag_a <= w_mag_1;
                    r_mag_b <= w_mag_2;
                    r_neg   <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
                end
                default: begin
                    r_neg <= operand_1[WIDTH-1];
                    r_rad <= operand_1[WIDTH-1] ? '0 : {operand_1, {FBITS{1'b0}}};
                end
            endcase
        end else if (r_state == MUL) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_mul_last) begin
                r_result   <= w_mul_res;
                r_overflow <= w_mul_ovf;
            end
        end else if (r_state == SQRT) begin
            r_rad  <= r_rad << 2;
            r_rem  <= w_rem_full[K:0];
            r_root <= w_root_nx;
            r_cnt  <= r_cnt + 1'b1;
            if (w_sqrt_last) begin
                r_result   <= r_neg ? '0 : {{(WIDTH-K){1'b0}}, w_root_nx};
                r_overflow <= r_neg;
            end
        end
    end

    assign result      = r_result;
    assign overflow    = r_overflow;
    assign ready       = (r_state == DONE);
    assign busy        = (r_state == MUL) || (r_state == SQRT);
    assign o_dbg_state = r_state;
endmodule

// File: tb/tb_fixed_point_engine.sv
// Bench for fixed_point_engine at default parameters (Q22.10, 16-bit slices).
module tb_fixed_point_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  operation;
    logic [31:0] operand_1, operand_2;
    logic [31:0] result;
    logic        ready, busy, overflow;
    logic [1:0]  o_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    fixed_point_engine dut (
        .clk(clk), .reset(reset), .start(start), .operation(operation),
        .operand_1(operand_1), .operand_2(operand_2), .result(result),
        .ready(ready), .busy(busy), .overflow(overflow), .o_dbg_state(o_dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain signed arithmetic and a binary-search square root.
    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic o, output int lat, output int bcy);
        longint sa, sb, s, ma, mb, q, x, root, t;
        bit neg;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = '0; o = 1'b0;
        case (op)
            2'd0, 2'd1: begin
                s = (op == 2'd0) ? sa + sb : sa - sb;
                lat = 1; bcy = 0;
                if (s > 64'sd2147483647)       begin r = 32'h7FFFFFFF; o = 1'b1; end
                else if (s < -64'sd2147483648) begin r = 32'h80000000; o = 1'b1; end
                else r = 32'(s);
            end
            2'd2: begin
                lat = 5; bcy = 4;
                ma = (sa < 0) ? -sa : sa;
                mb = (sb < 0) ? -sb : sb;
                q = (ma * mb) / 1024;
                neg = (sa < 0) != (sb < 0);
                if (neg) begin
                    if (q > 64'sd2147483648) begin r = 32'h80000000; o = 1'b1; end
                    else r = 32'(-q);
                end else begin
                    if (q > 64'sd2147483647) begin r = 32'h7FFFFFFF; o = 1'b1; end
                    else r = 32'(q);
                end
            end
            default: begin
                lat = 22; bcy = 21;
                if (sa < 0) begin r = '0; o = 1'b1; end
                else begin
                    x = sa * 1024;
                    root = 0;
                    for (int bit_i = 20; bit_i >= 0; bit_i--) begin
                        t = root + (64'sd1 <<< bit_i);
                        if (t * t <= x) root = t;
                    end
                    r = 32'(root);
                end
            end
        endcase
    endtask

    // Driver: issue one operation, scramble inputs afterwards, optionally
    // pulse start while busy, then check result/flags/latency/busy length.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit poke);
        logic [31:0] er;
        logic        eo;
        int          el, eb, lat, bcy;
        model(op, a, b, er, eo, el, eb);
        @(negedge clk);
        start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
        @(negedge clk);
        start = 1'b0;
        operation = 2'($urandom); operand_1 = $urandom; operand_2 = $urandom;
        lat = 1; bcy = 0;
        while (!ready && lat < 200) begin
            if (busy) bcy++;
            start = (poke && lat == 3);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check({tag, "/latency"}, 64'(lat), 64'(el));
        check({tag, "/result"}, 64'(result), 64'(er));
        check({tag, "/overflow"}, 64'(overflow), 64'(eo));
        check({tag, "/busy_cycles"}, 64'(bcy), 64'(eb));
        @(negedge clk);
        check({tag, "/ready_pulse"}, 64'(ready), 64'd0);
    endtask

    // Directed steps, then randomized traffic, then report.
    initial begin
        int rdy_seen;
        logic [31:0] edges [5];
        logic [31:0] a, b;
        edges = '{32'h80000000, 32'h7FFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h00000400};

        reset = 1'b1; start = 1'b0; operation = '0; operand_1 = '0; operand_2 = '0;
        repeat (3) @(negedge clk);
        check("reset/result", 64'(result), 64'd0);
        check("reset/ready", 64'(ready), 64'd0);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/overflow", 64'(overflow), 64'd0);
        reset = 1'b0;

        run_op("add_3p0_2p0", 2'd0, 32'h00000C00, 32'h00000800, 1'b0);
        check("add_3p0_2p0/const", 64'(result), 64'h00001400);
        run_op("add_sat_pos", 2'd0, 32'h7FFFFFFF, 32'h00000400, 1'b0);
        run_op("sub_sat_neg", 2'd1, 32'h80000000, 32'h00000001, 1'b0);
        run_op("mul_3p0_m2p5", 2'd2, 32'h00000C00, 32'hFFFFF600, 1'b0);
        check("mul_3p0_m2p5/const", 64'(result), 64'hFFFFE200);
        run_op("sqrt_16", 2'd3, 32'h00004000, 32'h0, 1'b0);
        check("sqrt_16/const", 64'(result), 64'h00001000);
        run_op("sqrt_2", 2'd3, 32'h00000800, 32'h0, 1'b0);
        check("sqrt_2/const", 64'(result), 64'h000005A8);
        run_op("sqrt_neg", 2'd3, 32'hFFFFFC00, 32'h0, 1'b0);
        run_op("sqrt_zero", 2'd3, 32'h00000000, 32'h0, 1'b0);
        run_op("sqrt_poke", 2'd3, 32'h00004000, 32'h00000400, 1'b1);
        run_op("mul_min_min", 2'd2, 32'h80000000, 32'h80000000, 1'b0);
        run_op("mul_min_1", 2'd2, 32'h80000000, 32'h00000400, 1'b0);
        run_op("mul_3p0_2p0", 2'd2, 32'h00000C00, 32'h00000800, 1'b0);

        // Reset in the third MUL cycle discards the operation.
        @(negedge clk);
        start = 1'b1; operation = 2'd2; operand_1 = 32'h00000C00; operand_2 = 32'h00000C00;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midreset/busy", 64'(busy), 64'd0);
        check("midreset/ready", 64'(ready), 64'd0);
        check("midreset/result", 64'(result), 64'd0);
        check("midreset/overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        rdy_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (ready) rdy_seen++;
        end
        check("midreset/no_ready", 64'(rdy_seen), 64'd0);
        run_op("add_after_reset", 2'd0, 32'h00000400, 32'h00000400, 1'b0);
        check("add_after_reset/const", 64'(result), 64'h00000800);

        // Randomized operations against the model.
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0: begin a = $urandom; b = $urandom; end
                1: begin
                    a = 32'($signed($urandom_range(0, 131071)) - 65536);
                    b = 32'($signed($urandom_range(0, 131071)) - 65536);
                end
                default: begin
                    a = edges[$urandom_range(0, 4)];
                    b = edges[$urandom_range(0, 4)];
                end
            endcase
            run_op($sformatf("rand%0d", i), 2'($urandom_range(0, 3)), a, b, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
